// File: rtl/sample_serializer.sv
// sample_serializer: buffers fixed-width timetag records in a small FIFO and
// serializes each one MSB-byte-first onto the sample/sample_rdy/sample_ack
// byte handshake. Records that arrive while the FIFO is full are dropped and
// counted in a saturating lost counter.
module sample_serializer #(
  parameter int unsigned REC_BYTES  = 6,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                    fx2_clk,
  input  logic                    reset_n,
  input  logic [8*REC_BYTES-1:0]  rec_in,
  input  logic                    rec_wr,
  output logic                    rec_full,
  output logic [DEPTH_LOG2:0]     rec_count,
  output logic [15:0]             lost_count,
  input  logic                    lost_clr,
  output logic [7:0]              sample,
  output logic                    sample_rdy,
  input  logic                    sample_ack
);

  localparam int unsigned REC_W    = 8 * REC_BYTES;
  localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W    = DEPTH_LOG2 + 1;
  localparam int unsigned IDX_W    = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
  localparam int unsigned LAST_IDX = REC_BYTES - 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_BUSY  = 1'b1
  } state_t;

  state_t                  state;
  logic [REC_W-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [REC_W-1:0]        out_shift;
  logic [IDX_W-1:0]        idx;

  logic                    wr_ok;
  logic                    drop;
  logic                    last_byte;
  logic                    pop;
  logic [CNT_W-1:0]        count_nxt;

  // Head byte of the output record; the record shifts left as bytes are acked.
  assign sample = out_shift[REC_W-1 -: 8];

  // Write acceptance, pop decision and next FIFO occupancy.
  always_comb begin
    wr_ok     = 1'b0;
    drop      = 1'b0;
    last_byte = 1'b0;
    pop       = 1'b0;
    count_nxt = rec_count;

    // Acceptance uses the registered full flag, so a same-cycle pop never frees a slot early.
    wr_ok     = rec_wr && !rec_full;
    drop      = rec_wr && rec_full;
    last_byte = (idx == IDX_W'(LAST_IDX));
    // Pops only read the registered count, so a record written this cycle waits one edge.
    pop       = (rec_count != '0) &&
                ((state == S_EMPTY) || (sample_ack && last_byte));

    unique case ({wr_ok, pop})
      2'b10:   count_nxt = rec_count + CNT_W'(1);
      2'b01:   count_nxt = rec_count - CNT_W'(1);
      default: count_nxt = rec_count;
    endcase
  end

  // Record storage; contents need no reset because the pointers define validity.
  always_ff @(posedge fx2_clk) begin
    if (reset_n && wr_ok) begin
      mem[wr_ptr] <= rec_in;
    end
  end

  // FIFO pointers, occupancy, full flag and saturating drop counter.
  always_ff @(posedge fx2_clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rec_count  <= '0;
      rec_full   <= 1'b0;
      lost_count <= 16'h0000;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      rec_count <= count_nxt;
      rec_full  <= (count_nxt == CNT_W'(DEPTH));
      if (lost_clr) begin
        lost_count <= drop ? 16'h0001 : 16'h0000;
      end else if (drop && (lost_count != 16'hFFFF)) begin
        lost_count <= lost_count + 16'h0001;
      end
    end
  end

  // Output FSM: loads records from the FIFO and steps through their bytes.
  always_ff @(posedge fx2_clk) begin
    if (!reset_n) begin
      state      <= S_EMPTY;
      sample_rdy <= 1'b0;
      idx        <= '0;
      out_shift  <= '0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (pop) begin
            out_shift  <= mem[rd_ptr];
            idx        <= '0;
            sample_rdy <= 1'b1;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (sample_ack) begin
            if (!last_byte) begin
              idx       <= idx + IDX_W'(1);
              out_shift <= out_shift << 8;
            end else if (pop) begin
              out_shift <= mem[rd_ptr];
              idx       <= '0;
            end else begin
              idx        <= '0;
              sample_rdy <= 1'b0;
              state      <= S_EMPTY;
            end
          end
        end
        default: begin
          state      <= S_EMPTY;
          sample_rdy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// tb_sample_serializer: directed stimulus with a byte scoreboard; stimulus
// pushes expected bytes, a negedge monitor pops them on every acked byte.
module tb_sample_serializer;

  localparam int unsigned REC_BYTES  = 6;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned REC_W      = 8 * REC_BYTES;

  logic                  fx2_clk = 1'b0;
  logic                  reset_n;
  logic [REC_W-1:0]      rec_in;
  logic                  rec_wr;
  logic                  rec_full;
  logic [DEPTH_LOG2:0]   rec_count;
  logic [15:0]           lost_count;
  logic                  lost_clr;
  logic [7:0]            sample;
  logic                  sample_rdy;
  logic                  sample_ack;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  sample_serializer #(.REC_BYTES(REC_BYTES), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .fx2_clk    (fx2_clk),
    .reset_n    (reset_n),
    .rec_in     (rec_in),
    .rec_wr     (rec_wr),
    .rec_full   (rec_full),
    .rec_count  (rec_count),
    .lost_count (lost_count),
    .lost_clr   (lost_clr),
    .sample     (sample),
    .sample_rdy (sample_rdy),
    .sample_ack (sample_ack)
  );

  always #5 fx2_clk = ~fx2_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Record whose bytes, MSB first, are base, base+1, ..., base+5.
  function automatic logic [REC_W-1:0] mkrec(input int base);
    logic [REC_W-1:0] r;
    for (int b = 0; b < int'(REC_BYTES); b++) r[REC_W-1-8*b -: 8] = 8'(base + b);
    return r;
  endfunction

  task automatic push_bytes(input logic [REC_W-1:0] r, input int nbytes);
    for (int b = 0; b < nbytes; b++) exp_q.push_back(r[REC_W-1-8*b -: 8]);
  endtask

  task automatic tick();
    @(posedge fx2_clk);
    #1;
  endtask

  // Monitor: every byte consumed by the FX2 side must match the scoreboard head.
  always @(negedge fx2_clk) begin
    if (reset_n && sample_rdy && sample_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(sample), 32'hFFFF_FFFF);
      end else begin
        chk("byte", 32'(sample), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [REC_W-1:0] r;
    reset_n = 1'b0; rec_in = '0; rec_wr = 1'b0; lost_clr = 1'b0; sample_ack = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_rdy", 32'(sample_rdy), 0);
    chk("rst_count", 32'(rec_count), 0);
    chk("rst_full", 32'(rec_full), 0);
    chk("rst_lost", 32'(lost_count), 0);
    chk("rst_sample", 32'(sample), 0);

    // Single record, ack held high.
    sample_ack = 1'b1;
    r = 48'h0A0B0C0D0E0F; push_bytes(r, 6);
    rec_in = r; rec_wr = 1'b1;
    tick();
    rec_wr = 1'b0;
    chk("single_count_e0", 32'(rec_count), 1);
    chk("single_rdy_e0", 32'(sample_rdy), 0);
    tick();
    chk("single_rdy_e1", 32'(sample_rdy), 1);
    chk("single_first", 32'(sample), 32'h0A);
    chk("single_count_e1", 32'(rec_count), 0);
    repeat (6) tick();
    chk("single_rdy_end", 32'(sample_rdy), 0);
    chk("single_q_empty", 32'(exp_q.size()), 0);

    // Back-to-back records; first is popped at the edge the second is written.
    push_bytes(48'h111111111111, 6); push_bytes(48'h222222222222, 6);
    rec_in = 48'h111111111111; rec_wr = 1'b1;
    tick();
    chk("b2b_count_e0", 32'(rec_count), 1);
    rec_in = 48'h222222222222;
    tick();
    rec_wr = 1'b0;
    chk("b2b_count_e1", 32'(rec_count), 1);
    for (int i = 0; i < 12; i++) begin
      chk("b2b_rdy", 32'(sample_rdy), 1);
      chk("b2b_count", 32'(rec_count), (i < 6) ? 1 : 0);
      tick();
    end
    chk("b2b_rdy_end", 32'(sample_rdy), 0);
    chk("b2b_q_empty", 32'(exp_q.size()), 0);

    // Backpressure after the first byte.
    sample_ack = 1'b0;
    r = 48'hA1A2A3A4A5A6; push_bytes(r, 6);
    rec_in = r; rec_wr = 1'b1;
    tick();
    rec_wr = 1'b0;
    tick();
    chk("bp_first", 32'(sample), 32'hA1);
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_sample", 32'(sample), 32'hA2);
      chk("bp_hold_rdy", 32'(sample_rdy), 1);
    end
    sample_ack = 1'b1;
    repeat (5) tick();
    chk("bp_rdy_end", 32'(sample_rdy), 0);
    chk("bp_q_empty", 32'(exp_q.size()), 0);

    // Overflow: 20 writes with no ack -> 1 in output register, 16 queued, 3 lost.
    sample_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = mkrec(8'h40 + 8 * i);
      if (i < 17) push_bytes(r, 6);
      rec_in = r; rec_wr = 1'b1;
      tick();
    end
    rec_wr = 1'b0;
    chk("ovf_full", 32'(rec_full), 1);
    chk("ovf_count", 32'(rec_count), 16);
    chk("ovf_lost", 32'(lost_count), 3);
    chk("ovf_rdy", 32'(sample_rdy), 1);
    chk("ovf_head", 32'(sample), 32'h40);
    // Writes during the 6 acks: the pop on the last one must not admit a write.
    sample_ack = 1'b1; rec_in = 48'hDEADDEADDEAD; rec_wr = 1'b1;
    repeat (6) tick();
    rec_wr = 1'b0;
    chk("ovf_pop_lost", 32'(lost_count), 9);
    chk("ovf_pop_count", 32'(rec_count), 15);
    chk("ovf_pop_full", 32'(rec_full), 0);
    repeat (96) tick();
    chk("ovf_drain_rdy", 32'(sample_rdy), 0);
    chk("ovf_drain_count", 32'(rec_count), 0);
    chk("ovf_q_empty", 32'(exp_q.size()), 0);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    chk("clr_lost", 32'(lost_count), 0);

    // Saturation: fill (17 accepted) then 65540 drops; then clear with a drop.
    sample_ack = 1'b0; rec_in = 48'h55AA55AA55AA; rec_wr = 1'b1;
    for (int i = 0; i < 17 + 65540; i++) tick();
    chk("sat_lost", 32'(lost_count), 32'hFFFF);
    chk("sat_full", 32'(rec_full), 1);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0; rec_wr = 1'b0;
    chk("clr_drop_lost", 32'(lost_count), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("sat_rst_count", 32'(rec_count), 0);

    // Reset mid-record: 3 of 6 bytes sent, 4 records queued.
    r = mkrec(8'h90); push_bytes(r, 3);
    for (int i = 0; i < 5; i++) begin
      rec_in = mkrec(8'h90 + 8 * i); rec_wr = 1'b1;
      tick();
    end
    rec_wr = 1'b0;
    chk("mid_count", 32'(rec_count), 4);
    sample_ack = 1'b1;
    repeat (3) tick();
    sample_ack = 1'b0;
    chk("mid_sample", 32'(sample), 32'h93);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_rdy", 32'(sample_rdy), 0);
    chk("mid_rst_count", 32'(rec_count), 0);
    chk("mid_rst_lost", 32'(lost_count), 0);
    chk("mid_rst_full", 32'(rec_full), 0);
    chk("mid_q_empty", 32'(exp_q.size()), 0);
    sample_ack = 1'b1;
    r = 48'hC1C2C3C4C5C6; push_bytes(r, 6);
    rec_in = r; rec_wr = 1'b1;
    tick();
    rec_wr = 1'b0;
    tick();
    chk("fresh_first", 32'(sample), 32'hC1);
    repeat (6) tick();
    chk("fresh_rdy_end", 32'(sample_rdy), 0);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
